// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversamples SCL/SDA, matches a 7-bit device address,
// and reads/writes an external 8-bit register file through an auto-incrementing
// pointer. SDA is driven open-drain through sdaDriveLow.
module i2c_slave_responder #(
    parameter logic [6:0] slaveAddress = 7'h50
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaDriveLow,
    output logic [7:0] regAddress,
    output logic [7:0] regWriteData,
    output logic       regWriteEnable,
    input  logic [7:0] regReadData,
    output logic       busy
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] ADDR       = 4'd1;
    localparam logic [3:0] ADDR_ACK   = 4'd2;
    localparam logic [3:0] IGNORE     = 4'd3;
    localparam logic [3:0] PTR_BYTE   = 4'd4;
    localparam logic [3:0] WRITE_BYTE = 4'd5;
    localparam logic [3:0] WRITE_ACK  = 4'd6;
    localparam logic [3:0] READ_BYTE  = 4'd7;
    localparam logic [3:0] READ_ACK   = 4'd8;

    logic       sclMeta, sclSync, sclPrev;
    logic       sdaMeta, sdaSync, sdaPrev;
    logic       sclRise, sclFall, startCond, stopCond;

    logic [3:0] state;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic       byteDone;    // phase flag: all 8 bits of the current byte are in
    logic       rw;
    logic       ackSeen;     // master ACKed the last read byte
    logic       incPending;  // bump the pointer on the cycle after a strobe/read load

    // Two-flop synchronizers plus a history flop; idle bus is high so reset to 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {sclMeta, sclSync, sclPrev} <= 3'b111;
            {sdaMeta, sdaSync, sdaPrev} <= 3'b111;
        end else begin
            {sclMeta, sclSync, sclPrev} <= {sclIn, sclMeta, sclSync};
            {sdaMeta, sdaSync, sdaPrev} <= {sdaIn, sdaMeta, sdaSync};
        end
    end

    assign sclRise   = sclSync & ~sclPrev;
    assign sclFall   = ~sclSync & sclPrev;
    assign startCond = sclSync & sclPrev & sdaPrev & ~sdaSync;
    assign stopCond  = sclSync & sclPrev & ~sdaPrev & sdaSync;

    // Protocol FSM; START/STOP take priority over any same-cycle SCL edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shiftReg       <= 8'h00;
            bitCnt         <= 3'd0;
            byteDone       <= 1'b0;
            rw             <= 1'b0;
            ackSeen        <= 1'b0;
            incPending     <= 1'b0;
            sdaDriveLow    <= 1'b0;
            regAddress     <= 8'h00;
            regWriteData   <= 8'h00;
            regWriteEnable <= 1'b0;
            busy           <= 1'b0;
        end else begin
            regWriteEnable <= 1'b0;
            if (incPending) begin
                regAddress <= regAddress + 8'd1;
                incPending <= 1'b0;
            end

            if (startCond) begin
                state       <= ADDR;
                sdaDriveLow <= 1'b0;
                bitCnt      <= 3'd0;
                byteDone    <= 1'b0;
            end else if (stopCond) begin
                state       <= IDLE;
                sdaDriveLow <= 1'b0;
                busy        <= 1'b0;
                bitCnt      <= 3'd0;
                byteDone    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR_BYTE, WRITE_BYTE: begin
                        if (sclRise && !byteDone) begin
                            shiftReg <= {shiftReg[6:0], sdaSync};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) byteDone <= 1'b1;
                        end else if (sclFall && byteDone) begin
                            bitCnt   <= 3'd0;
                            byteDone <= 1'b0;
                            if (state == ADDR) begin
                                if (shiftReg[7:1] == slaveAddress) begin
                                    state       <= ADDR_ACK;
                                    sdaDriveLow <= 1'b1;
                                    rw          <= shiftReg[0];
                                    busy        <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR_BYTE) begin
                                // Pointer byte is acknowledged but never strobed
                                regAddress  <= shiftReg;
                                state       <= WRITE_ACK;
                                sdaDriveLow <= 1'b1;
                            end else begin
                                regWriteData   <= shiftReg;
                                regWriteEnable <= 1'b1;
                                incPending     <= 1'b1;
                                state          <= WRITE_ACK;
                                sdaDriveLow    <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (sclFall) begin
                            if (rw) begin
                                shiftReg    <= regReadData;
                                sdaDriveLow <= ~regReadData[7];
                                incPending  <= 1'b1;
                                bitCnt      <= 3'd0;
                                state       <= READ_BYTE;
                            end else begin
                                sdaDriveLow <= 1'b0;
                                state       <= PTR_BYTE;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (sclFall) begin
                            sdaDriveLow <= 1'b0;
                            state       <= WRITE_BYTE;
                        end
                    end
                    READ_BYTE: begin
                        // Bit 7 went out on entry; each fall presents the next bit
                        if (sclFall) begin
                            if (bitCnt == 3'd7) begin
                                sdaDriveLow <= 1'b0;
                                ackSeen     <= 1'b0;
                                state       <= READ_ACK;
                            end else begin
                                shiftReg    <= {shiftReg[6:0], 1'b0};
                                sdaDriveLow <= ~shiftReg[6];
                                bitCnt      <= bitCnt + 3'd1;
                            end
                        end
                    end
                    READ_ACK: begin
                        if (sclRise) begin
                            if (sdaSync) state <= IGNORE;
                            else         ackSeen <= 1'b1;
                        end else if (sclFall && ackSeen) begin
                            shiftReg    <= regReadData;
                            sdaDriveLow <= ~regReadData[7];
                            incPending  <= 1'b1;
                            bitCnt      <= 3'd0;
                            state       <= READ_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master drives the bus, a
// scoreboard holds expected write strobes and read bytes, and a monitor on the
// falling system clock edge pops and compares them.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       mDrive = 1'b0;
    logic       sdaBus;
    logic       sdaDriveLow;
    logic [7:0] regAddress, regWriteData, regReadData;
    logic       regWriteEnable, busy;

    int nCmp = 0;
    int nBad = 0;

    logic [15:0] expWr[$];
    logic [7:0]  expRd[$];
    logic [7:0]  obsRd[$];
    logic        weLast = 1'b0;
    logic        sawDrive = 1'b0;
    logic        sawBusy = 1'b0;

    assign sdaBus = ~(mDrive | sdaDriveLow);

    always #5 clock = ~clock;

    // Small register model
    always_comb begin
        regReadData = 8'hEE;
        case (regAddress)
            8'h20: regReadData = 8'h5A;
            8'h21: regReadData = 8'h3C;
            default: regReadData = 8'hEE;
        endcase
    end

    i2c_slave_responder #(.slaveAddress(7'h50)) dut (
        .clock(clock), .reset_n(reset_n), .sclIn(scl), .sdaIn(sdaBus),
        .sdaDriveLow(sdaDriveLow), .regAddress(regAddress),
        .regWriteData(regWriteData), .regWriteEnable(regWriteEnable),
        .regReadData(regReadData), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or the master delivers a read byte
    always @(negedge clock) begin
        logic [15:0] e;
        logic [7:0]  r, o;
        if (regWriteEnable) begin
            if (weLast) check("we_width", 32'd2, 32'd1);
            if (expWr.size() == 0) begin
                check("wr_unexpected", {16'h0, regAddress, regWriteData}, 32'hFFFFFFFF);
            end else begin
                e = expWr.pop_front();
                check("wr_addr", {24'h0, regAddress}, {24'h0, e[15:8]});
                check("wr_data", {24'h0, regWriteData}, {24'h0, e[7:0]});
            end
        end
        weLast = regWriteEnable;
        if (obsRd.size() > 0) begin
            o = obsRd.pop_front();
            if (expRd.size() == 0) begin
                check("rd_unexpected", {24'h0, o}, 32'hFFFFFFFF);
            end else begin
                r = expRd.pop_front();
                check("rd_byte", {24'h0, o}, {24'h0, r});
            end
        end
        if (sdaDriveLow) sawDrive = 1'b1;
        if (busy)        sawBusy = 1'b1;
    end

    // Bus primitives; SCL quarter period is 50 ns (20 system clocks per SCL)
    task automatic clkBit(input logic drv, output logic smp);
        mDrive = drv;
        #50 scl = 1'b1;
        #50 smp = sdaBus;
        #50 scl = 1'b0;
        #50;
    endtask

    task automatic startCond();
        mDrive = 1'b0;
        #50 scl = 1'b1;
        #100 mDrive = 1'b1;
        #100 scl = 1'b0;
        #50;
    endtask

    task automatic stopCond();
        mDrive = 1'b1;
        #50 scl = 1'b1;
        #100 mDrive = 1'b0;
        #100;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 7; i > 7 - n; i--) clkBit(~b[i], s);
    endtask

    task automatic writeByte(input logic [7:0] b, input logic expAck, input string name);
        logic a;
        sendBits(b, 8);
        clkBit(1'b0, a);
        check(name, {31'h0, a}, {31'h0, ~expAck});
    endtask

    task automatic readByte(input logic ack);
        logic [7:0] b;
        logic s;
        for (int i = 7; i >= 0; i--) clkBit(1'b0, b[i]);
        clkBit(ack, s);
        obsRd.push_back(b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic s;
        // Reset values
        #23;
        check("rst_sda", {31'h0, sdaDriveLow}, 32'h0);
        check("rst_we", {31'h0, regWriteEnable}, 32'h0);
        check("rst_addr", {24'h0, regAddress}, 32'h0);
        check("rst_wdata", {24'h0, regWriteData}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        #17 reset_n = 1'b1;
        #200;

        // 1: register write with auto-increment
        expWr.push_back({8'h10, 8'hAB});
        expWr.push_back({8'h11, 8'hCD});
        startCond();
        writeByte(8'hA0, 1'b1, "t1_addr_ack");
        check("t1_busy", {31'h0, busy}, 32'h1);
        writeByte(8'h10, 1'b1, "t1_ptr_ack");
        writeByte(8'hAB, 1'b1, "t1_d0_ack");
        writeByte(8'hCD, 1'b1, "t1_d1_ack");
        stopCond();
        #100;
        check("t1_ptr_final", {24'h0, regAddress}, 32'h12);
        check("t1_busy_after", {31'h0, busy}, 32'h0);

        // 2: pointer set then read via repeated START
        startCond();
        writeByte(8'hA0, 1'b1, "t2_addr_ack");
        writeByte(8'h20, 1'b1, "t2_ptr_ack");
        startCond();
        writeByte(8'hA1, 1'b1, "t2_raddr_ack");
        expRd.push_back(8'h5A);
        expRd.push_back(8'h3C);
        readByte(1'b1);
        readByte(1'b0);
        sawDrive = 1'b0;
        clkBit(1'b0, s);
        clkBit(1'b0, s);
        check("t2_released", {31'h0, sawDrive}, 32'h0);
        stopCond();
        #100;
        check("t2_ptr_final", {24'h0, regAddress}, 32'h22);

        // 3: address mismatch
        sawDrive = 1'b0;
        sawBusy = 1'b0;
        startCond();
        writeByte(8'hA2, 1'b0, "t3_addr_nack");
        writeByte(8'h10, 1'b0, "t3_b1_nack");
        writeByte(8'h99, 1'b0, "t3_b2_nack");
        stopCond();
        #100;
        check("t3_no_drive", {31'h0, sawDrive}, 32'h0);
        check("t3_no_busy", {31'h0, sawBusy}, 32'h0);
        check("t3_ptr_kept", {24'h0, regAddress}, 32'h22);

        // 4: pointer wrap
        expWr.push_back({8'hFF, 8'h11});
        expWr.push_back({8'h00, 8'h22});
        startCond();
        writeByte(8'hA0, 1'b1, "t4_addr_ack");
        writeByte(8'hFF, 1'b1, "t4_ptr_ack");
        writeByte(8'h11, 1'b1, "t4_d0_ack");
        writeByte(8'h22, 1'b1, "t4_d1_ack");
        stopCond();
        #100;
        check("t4_ptr_final", {24'h0, regAddress}, 32'h01);

        // 5a: STOP in the middle of a data byte
        startCond();
        writeByte(8'hA0, 1'b1, "t5_addr_ack");
        writeByte(8'h30, 1'b1, "t5_ptr_ack");
        sendBits(8'hF0, 4);
        stopCond();
        #100;
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_sda", {31'h0, sdaDriveLow}, 32'h0);
        check("t5_ptr", {24'h0, regAddress}, 32'h30);

        // 5b: reset during ADDR_ACK
        startCond();
        sendBits(8'hA0, 8);
        check("t5_ack_driven", {31'h0, sdaDriveLow}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_sda", {31'h0, sdaDriveLow}, 32'h0);
        check("t5_rst_we", {31'h0, regWriteEnable}, 32'h0);
        check("t5_rst_addr", {24'h0, regAddress}, 32'h0);
        check("t5_rst_wdata", {24'h0, regWriteData}, 32'h0);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        #20 scl = 1'b1;
        #20 reset_n = 1'b1;
        #200;

        check("wr_queue_empty", expWr.size(), 32'd0);
        check("rd_queue_empty", expRd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
